// File: rtl/uart_pkt_decoder_pkg.sv
// Shared definitions for the UART packet decoder and its companion response encoder.
package uart_pkt_decoder_pkg;

  typedef enum logic [1:0] {
    S_CMD   = 2'd0,
    S_ADDR  = 2'd1,
    S_DATA  = 2'd2,
    S_ISSUE = 2'd3
  } state_t;

  // Command byte layout: {sync, write, len[5:0]}
  localparam int unsigned CMD_SYNC_BIT  = 7;
  localparam int unsigned CMD_WRITE_BIT = 6;
  localparam int unsigned CMD_LEN_MSB   = 5;
  localparam int unsigned CMD_LEN_LSB   = 0;

  localparam int unsigned DEF_ADDR_WIDTH     = 32;
  localparam int unsigned DEF_WORD_WIDTH     = 32;
  localparam int unsigned DEF_LEN_WIDTH      = 6;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 100000;

endpackage

// File: rtl/uart_pkt_decoder.sv
// Decodes a UART byte stream of command/address/data packets into bus word requests,
// with sync-error detection and an inter-byte timeout.
module uart_pkt_decoder
  import uart_pkt_decoder_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int unsigned WORD_WIDTH     = DEF_WORD_WIDTH,
  parameter int unsigned LEN_WIDTH      = DEF_LEN_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic                  req_valid,
  input  logic                  req_ready,
  output logic                  req_write,
  output logic [ADDR_WIDTH-1:0] req_addr,
  output logic [WORD_WIDTH-1:0] req_wdata,
  output logic                  busy,
  output logic                  err_sync,
  output logic                  err_timeout
);

  localparam int unsigned ADDR_BYTES = ADDR_WIDTH / 8;
  localparam int unsigned WORD_BYTES = WORD_WIDTH / 8;
  localparam int unsigned MAX_BYTES  = (ADDR_BYTES > WORD_BYTES) ? ADDR_BYTES : WORD_BYTES;
  localparam int unsigned BCNT_W     = $clog2(MAX_BYTES + 1);
  localparam int unsigned TMO_W      = $clog2(TIMEOUT_CYCLES + 1);

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_write;
  logic [LEN_WIDTH-1:0]  r_len;
  logic [LEN_WIDTH-1:0]  r_word_cnt;
  logic [BCNT_W-1:0]     r_byte_cnt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [WORD_WIDTH-1:0] r_data;
  logic [TMO_W-1:0]      r_tmo_cnt;
  logic                  r_err_sync;
  logic                  r_err_timeout;

  logic w_accept;
  logic w_in_frame;
  logic w_addr_last;
  logic w_word_done;
  logic w_last_word;
  logic w_tmo_hit;
  logic w_err_sync_nxt;
  logic w_err_tmo_nxt;

  assign rx_ready    = (r_state != S_ISSUE);
  assign req_valid   = (r_state == S_ISSUE);
  assign busy        = (r_state != S_CMD);
  assign req_write   = r_write;
  assign req_addr    = r_addr;
  assign req_wdata   = r_data;
  assign err_sync    = r_err_sync;
  assign err_timeout = r_err_timeout;

  assign w_accept    = rx_valid && rx_ready;
  assign w_in_frame  = (r_state == S_ADDR) || (r_state == S_DATA);
  assign w_addr_last = (r_byte_cnt == BCNT_W'(ADDR_BYTES - 1));
  assign w_word_done = (r_byte_cnt == BCNT_W'(WORD_BYTES - 1));
  assign w_last_word = (r_word_cnt == r_len);
  assign w_tmo_hit   = w_in_frame && !w_accept && (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_CMD;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_err_sync_nxt = 1'b0;
    w_err_tmo_nxt  = 1'b0;
    case (r_state)
      S_CMD: begin
        if (w_accept) begin
          if (rx_data[CMD_SYNC_BIT]) w_state_nxt    = S_ADDR;
          else                       w_err_sync_nxt = 1'b1;
        end
      end
      S_ADDR: begin
        if (w_accept && w_addr_last) begin
          w_state_nxt = r_write ? S_DATA : S_ISSUE;
        end else if (w_tmo_hit) begin
          w_state_nxt   = S_CMD;
          w_err_tmo_nxt = 1'b1;
        end
      end
      S_DATA: begin
        if (w_accept && w_word_done) begin
          w_state_nxt = S_ISSUE;
        end else if (w_tmo_hit) begin
          w_state_nxt   = S_CMD;
          w_err_tmo_nxt = 1'b1;
        end
      end
      S_ISSUE: begin
        if (req_ready) begin
          if (w_last_word)  w_state_nxt = S_CMD;
          else if (r_write) w_state_nxt = S_DATA;
          else              w_state_nxt = S_ISSUE;
        end
      end
      default: w_state_nxt = S_CMD;
    endcase
  end

  // Datapath: command latch, MSB-first byte shifter, word/address stepping
  always_ff @(posedge clk) begin
    if (reset) begin
      r_write    <= 1'b0;
      r_len      <= '0;
      r_word_cnt <= '0;
      r_byte_cnt <= '0;
      r_addr     <= '0;
      r_data     <= '0;
    end else begin
      case (r_state)
        S_CMD: begin
          if (w_accept && rx_data[CMD_SYNC_BIT]) begin
            r_write    <= rx_data[CMD_WRITE_BIT];
            r_len      <= LEN_WIDTH'(rx_data[CMD_LEN_MSB:CMD_LEN_LSB]);
            r_word_cnt <= '0;
            r_byte_cnt <= '0;
            r_addr     <= '0;
            r_data     <= '0;
          end
        end
        S_ADDR: begin
          if (w_accept) begin
            r_addr     <= (r_addr << 8) | ADDR_WIDTH'(rx_data);
            r_byte_cnt <= w_addr_last ? '0 : r_byte_cnt + BCNT_W'(1);
          end
        end
        S_DATA: begin
          if (w_accept) begin
            r_data     <= (r_data << 8) | WORD_WIDTH'(rx_data);
            r_byte_cnt <= w_word_done ? '0 : r_byte_cnt + BCNT_W'(1);
          end
        end
        S_ISSUE: begin
          if (req_ready && !w_last_word) begin
            r_addr     <= r_addr + ADDR_WIDTH'(WORD_BYTES);
            r_word_cnt <= r_word_cnt + LEN_WIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Idle-gap counter only runs inside a packet while waiting for the next byte
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tmo_cnt <= '0;
    end else if (w_accept || !w_in_frame || w_tmo_hit) begin
      r_tmo_cnt <= '0;
    end else begin
      r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_err_sync    <= 1'b0;
      r_err_timeout <= 1'b0;
    end else begin
      r_err_sync    <= w_err_sync_nxt;
      r_err_timeout <= w_err_tmo_nxt;
    end
  end

endmodule

// File: doc/uart_pkt_decoder.md
UART_PKT_DECODER -- requirements
Module: uart_pkt_decoder

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, bus address width in bits (multiple of 8).
REQ-002 SHALL have parameter WORD_WIDTH, default 32, bus data word width in bits (multiple of 8).
REQ-003 SHALL have parameter LEN_WIDTH, default 6, width of the packet length field.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 100000, maximum allowed idle clk cycles between bytes inside a packet.
REQ-005 SHALL have port clk, input, 1, single clock; all logic is on its rising edge.
REQ-006 SHALL have port reset, input, 1; reset is synchronous and active-high.
REQ-007 SHALL have ports rx_data input 8, rx_valid input 1, rx_ready output 1: the byte stream from the UART receiver, transferred when rx_valid && rx_ready.
REQ-008 SHALL have ports req_valid output 1, req_ready input 1, req_write output 1, req_addr output ADDR_WIDTH, req_wdata output WORD_WIDTH: one bus word request, transferred when req_valid && req_ready.
REQ-009 SHALL have ports busy output 1 (high when not in S_CMD), err_sync output 1 (one-cycle pulse) and err_timeout output 1 (one-cycle pulse).

Function
REQ-010 Packet format SHALL be: a command byte {bit7=1, bit6=write, bits5:0=len}; then ADDR_WIDTH/8 address bytes, MSB first; then, for writes only, (WORD_WIDTH/8)*(len+1) data bytes, each word MSB first.
REQ-011 FSM states SHALL be S_CMD, S_ADDR, S_DATA, S_ISSUE.
- S_CMD: accept a byte; bit7=1 -> latch write and len, go to S_ADDR; bit7=0 -> discard byte, pulse err_sync, stay in S_CMD.
REQ-012 In S_ADDR the byte counter SHALL shift each byte into the address register; after the last address byte go to S_DATA if write, else S_ISSUE.
REQ-013 In S_DATA each completed word SHALL move to S_ISSUE; req_wdata is the assembled word.
REQ-014 S_ISSUE SHALL assert req_valid and hold req_write, req_addr and req_wdata stable until req_ready.
- On the handshake: words remaining -> add WORD_WIDTH/8 to the address (modulo 2^ADDR_WIDTH, wrap permitted) and return to S_DATA (write) or stay in S_ISSUE (read).
- Last word -> S_CMD.
REQ-015 A read packet SHALL issue len+1 requests with req_wdata=0 and consecutive word addresses.
REQ-016 rx_ready SHALL be 1 in S_CMD, S_ADDR and S_DATA, and 0 in S_ISSUE; no byte is dropped under backpressure.
REQ-017 First request latency SHALL be: req_valid asserted the cycle after the handshake of the last required byte.
REQ-018 Timeout counter:
- clears on every accepted byte and on entry to S_CMD;
- counts only in S_ADDR and S_DATA while no byte is accepted;
- on reaching TIMEOUT_CYCLES: pulse err_timeout, discard the partial packet, go to S_CMD.
- An already issued request is never retracted.
REQ-019 len=0 SHALL mean exactly one word; len=2^LEN_WIDTH-1 SHALL mean 2^LEN_WIDTH words.

Reset
REQ-020 On reset the FSM SHALL go to S_CMD and clear the counters, address, data, write and len registers.
REQ-021 Outputs during and after reset SHALL be: rx_ready=1, req_valid=0, req_write=0, req_addr=0, req_wdata=0, busy=0, err_sync=0, err_timeout=0.
REQ-022 Reset asserted mid-packet or mid-request SHALL abort it with no further request.

Structure
REQ-023 The shared package SHALL hold the FSM state typedef, the command-byte field positions (SYNC bit 7, WRITE bit 6, LEN bits 5:0) and the default width constants, for reuse by the response encoder.
REQ-024 The block SHALL be one module with no sub-modules; the MSB-first byte-to-word shifter is inline.

Verification
REQ-025 Write 0xC0, 0x60 00 04 00, 0x00 00 00 01, req_ready=1 -> one request: write=1, addr=0x60000400, wdata=0x00000001; busy drops after it.
REQ-026 Read 0x82, addr 0x10000000 -> three requests: write=0, addrs 0x10000000, 0x10000004, 0x10000008; wdata=0.
REQ-027 Byte 0x55 before a valid write packet -> one err_sync pulse; the following packet decodes correctly.
REQ-028 Write len=1 to 0xFFFFFFFC, req_ready held 0 for 50 cycles -> rx_ready=0 and request stable; the second request goes to 0x00000000 with the second word.
REQ-029 Stall after 2 address bytes for TIMEOUT_CYCLES -> one err_timeout pulse, no request, next packet decoded normally.
REQ-030 Reset during S_DATA -> all outputs at reset values the next cycle; no request issued.
